// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and the bit
// positions of the SR and Cause fields implemented by cp0_exc_unit.
package cp0_pkg;

  // CP0 register numbers reachable through mfc0/mtc0
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // ExcCode values delivered down the pipeline to the M stage
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // SR field positions
  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LO   = 10;
  localparam int SR_IM_HI   = 15;

  // Cause field positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD_BIT = 31;

endpackage

// File: rtl/cp0_exc_unit.sv
// CP0 exception responder for the M stage. Raises a combinational req that
// flushes the pipeline and redirects fetch, records Cause/EPC on the taking
// edge, and holds SR, Cause, EPC and PRId for mfc0/mtc0 and eret.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h5037_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exc_code,
  input  logic        m_eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  // SR fields
  logic [5:0]  sr_im_q,   sr_im_d;
  logic        sr_exl_q,  sr_exl_d;
  logic        sr_ie_q,   sr_ie_d;
  // Cause fields
  logic        cause_bd_q,  cause_bd_d;
  logic [5:0]  cause_ip_q,  cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic int_req;
  logic exc_req;

  // Request decode: interrupts win over the synchronous exception, and
  // EXL masks both so a handler is never re-entered.
  always_comb begin
    int_req = sr_ie_q & ~sr_exl_q & (|(hw_int & sr_im_q));
    exc_req = (m_exc_code != EXC_INT) & ~sr_exl_q;
    req     = (int_req | exc_req) & ~reset;
  end

  // Next-state for SR/Cause/EPC; taking an exception discards any mtc0/eret
  // in the same cycle, and eret overrides the EXL bit of a coincident mtc0.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = int_req ? EXC_INT : m_exc_code;
      cause_bd_d  = m_bd;
      epc_d       = m_bd ? (m_pc - 32'd4) : m_pc;
    end else begin
      if (cp0_we) begin
        case (cp0_addr)
          CP0_SR: begin
            sr_im_d  = cp0_wdata[SR_IM_HI:SR_IM_LO];
            sr_exl_d = cp0_wdata[SR_EXL_BIT];
            sr_ie_d  = cp0_wdata[SR_IE_BIT];
          end
          CP0_EPC: epc_d = cp0_wdata;
          default: ;
        endcase
      end
      if (m_eret) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  // State registers; reset clears all writable CP0 state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // mfc0 read mux over pre-edge state; unimplemented bits/registers read 0.
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_SR: begin
        cp0_rdata[SR_IM_HI:SR_IM_LO] = sr_im_q;
        cp0_rdata[SR_EXL_BIT]        = sr_exl_q;
        cp0_rdata[SR_IE_BIT]         = sr_ie_q;
      end
      CP0_CAUSE: begin
        cp0_rdata[CAUSE_BD_BIT]              = cause_bd_q;
        cp0_rdata[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip_q;
        cp0_rdata[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc_q;
      end
      CP0_EPC:  cp0_rdata = epc_q;
      CP0_PRID: cp0_rdata = PRID_VAL;
      default:  cp0_rdata = '0;
    endcase
  end

  assign handler_pc = HANDLER_ADDR;
  assign epc_out    = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: a word-level model of SR/Cause/EPC checked every
// negative edge, plus directed scenarios with literal expectations.
module tb_cp0_exc_unit;

  localparam logic [31:0] HADDR = 32'h0000_4180;
  localparam logic [31:0] PRID  = 32'h5037_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc_code;
  logic        m_eret;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  cp0_exc_unit #(.HANDLER_ADDR(HADDR), .PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .m_pc(m_pc), .m_bd(m_bd),
    .m_exc_code(m_exc_code), .m_eret(m_eret), .cp0_we(cp0_we),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .hw_int(hw_int), .req(req), .handler_pc(handler_pc), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  // Model state as whole architectural words
  logic [31:0] md_sr, md_cause, md_epc;

  function automatic logic mdl_irq();
    return md_sr[0] && !md_sr[1] && ((hw_int & md_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic mdl_req();
    return !reset && (mdl_irq() || ((m_exc_code != 5'd0) && !md_sr[1]));
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [4:0] a);
    case (a)
      5'd12:   return md_sr;
      5'd13:   return md_cause;
      5'd14:   return md_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] nsr();
    logic [31:0] r;
    if (reset) return 32'd0;
    if (mdl_req()) return md_sr | 32'h2;
    r = md_sr;
    if (cp0_we && cp0_addr == 5'd12) r = cp0_wdata & 32'h0000_FC03;
    if (m_eret) r = r & ~32'h2;
    return r;
  endfunction

  function automatic logic [31:0] ncause();
    logic [31:0] r;
    logic [4:0]  code;
    if (reset) return 32'd0;
    r = md_cause;
    if (mdl_req()) begin
      code = mdl_irq() ? 5'd0 : m_exc_code;
      r = {m_bd, 31'd0} | ({27'd0, code} << 2);
    end
    r[15:10] = hw_int;
    return r;
  endfunction

  function automatic logic [31:0] nepc();
    if (reset) return 32'd0;
    if (mdl_req()) return m_bd ? (m_pc - 32'd4) : m_pc;
    if (cp0_we && cp0_addr == 5'd14) return cp0_wdata;
    return md_epc;
  endfunction

  // Model advances on the same edge as the DUT
  always @(posedge clk) begin
    md_sr    <= nsr();
    md_cause <= ncause();
    md_epc   <= nepc();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mdl_req", {31'd0, req}, {31'd0, mdl_req()});
      chk("mdl_rdata", cp0_rdata, mdl_rd(cp0_addr));
      chk("mdl_epc_out", epc_out, md_epc);
      chk("handler_pc", handler_pc, HADDR);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [4:0] a, input string nm, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(nm, cp0_rdata, exp);
  endtask

  task automatic req_is(input string nm, input logic exp);
    #1;
    chk(nm, {31'd0, req}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b1; m_pc = '0; m_bd = 1'b0; m_exc_code = '0; m_eret = 1'b0;
    cp0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0; hw_int = '0;
    tick();
    cmp_en = 1'b1;
    // Reset state
    req_is("rst_req", 1'b0);
    peek(5'd12, "rst_sr", 32'd0);
    peek(5'd13, "rst_cause", 32'd0);
    peek(5'd14, "rst_epc", 32'd0);
    chk("rst_epc_out", epc_out, 32'd0);
    tick();
    reset = 1'b0;

    // 1: RI exception, not in delay slot
    m_exc_code = 5'd10; m_pc = 32'h3008; m_bd = 1'b0;
    req_is("t1_req", 1'b1);
    tick();
    req_is("t1_req_masked", 1'b0);
    peek(5'd13, "t1_cause", 32'h0000_0028);
    peek(5'd14, "t1_epc", 32'h0000_3008);
    peek(5'd12, "t1_sr", 32'h0000_0002);
    m_exc_code = 5'd0; m_eret = 1'b1;
    tick();
    m_eret = 1'b0;
    peek(5'd12, "t1_eret_sr", 32'd0);

    // 2: overflow in a delay slot
    m_exc_code = 5'd12; m_bd = 1'b1; m_pc = 32'h3010;
    tick();
    m_exc_code = 5'd0; m_bd = 1'b0;
    peek(5'd13, "t2_cause", 32'h8000_0030);
    peek(5'd14, "t2_epc", 32'h0000_300C);
    m_eret = 1'b1; tick(); m_eret = 1'b0;

    // EPC wrap for a delay-slot instruction at PC 0
    m_exc_code = 5'd10; m_bd = 1'b1; m_pc = 32'h0;
    tick();
    m_exc_code = 5'd0; m_bd = 1'b0;
    peek(5'd14, "wrap_epc", 32'hFFFF_FFFC);
    m_eret = 1'b1; tick(); m_eret = 1'b0;

    // 3: enable interrupts, take one; then interrupt beats syscall
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
    tick();
    cp0_we = 1'b0;
    peek(5'd12, "t3_sr", 32'h0000_FC01);
    m_pc = 32'h4000; hw_int = 6'b000100;
    req_is("t3_int_req", 1'b1);
    tick();
    hw_int = 6'b0;
    peek(5'd13, "t3_cause", 32'h0000_1000);
    peek(5'd14, "t3_epc", 32'h0000_4000);
    m_eret = 1'b1; tick(); m_eret = 1'b0;
    hw_int = 6'b000100; m_exc_code = 5'd8; m_pc = 32'h4100;
    req_is("t3_both_req", 1'b1);
    tick();
    peek(5'd13, "t3_both_cause", 32'h0000_1000);

    // 4: EXL masks everything; eret re-opens the pending interrupt
    m_exc_code = 5'd4; m_pc = 32'h4200;
    req_is("t4_masked", 1'b0);
    tick();
    peek(5'd14, "t4_epc_hold", 32'h0000_4100);
    m_exc_code = 5'd0; m_eret = 1'b1;
    req_is("t4_eret_req", 1'b0);
    tick();
    m_eret = 1'b0;
    req_is("t4_reopen", 1'b1);
    peek(5'd12, "t4_sr", 32'h0000_FC01);
    m_pc = 32'h5000;
    tick();
    hw_int = 6'b0;
    peek(5'd14, "t4_epc", 32'h0000_5000);
    tick();
    m_eret = 1'b1; tick(); m_eret = 1'b0;

    // 5: mtc0/mfc0 behaviour
    cp0_we = 1'b1; cp0_wdata = 32'hDEAD_BEE0;
    peek(5'd14, "t5_old_read", 32'h0000_5000);
    tick();
    cp0_we = 1'b0;
    peek(5'd14, "t5_epc", 32'hDEAD_BEE0);
    chk("t5_epc_out", epc_out, 32'hDEAD_BEE0);
    cp0_we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    tick();
    cp0_we = 1'b0;
    peek(5'd13, "t5_cause_ro", 32'd0);
    peek(5'd15, "t5_prid", PRID);
    peek(5'd7, "t5_undef", 32'd0);
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC03; m_eret = 1'b1;
    tick();
    cp0_we = 1'b0; m_eret = 1'b0;
    peek(5'd12, "t5_mtc0_eret", 32'h0000_FC01);

    // 6: reset in the middle of a handler
    m_exc_code = 5'd8; m_pc = 32'h6000;
    tick();
    reset = 1'b1;
    req_is("t6_rst_req", 1'b0);
    tick();
    peek(5'd12, "t6_sr", 32'd0);
    peek(5'd13, "t6_cause", 32'd0);
    peek(5'd14, "t6_epc", 32'd0);
    chk("t6_epc_out", epc_out, 32'd0);
    req_is("t6_rst_req2", 1'b0);
    reset = 1'b0;
    req_is("t6_post_req", 1'b1);
    tick();
    m_exc_code = 5'd0;
    peek(5'd14, "t6_epc_after", 32'h0000_6000);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
